wishbone_mem_responder: RTL and testbench

Wishbone classic responder (slave) with a word-addressed, byte-lane-writable memory and programmable wait states. It answers the `iBusWishbone_*`/`dBusWishbone_*` requests issued by the contranomy core in simulation benches and in formal runs where a deterministic memory replaces free-running ACK inputs. One instance serves one bus. Out-of-range accesses are terminated with ERR.

---
 rtl/wishbone_pkg.sv | 25 ++
 rtl/wishbone_mem_array.sv | 48 ++++
 rtl/wishbone_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_wishbone_mem_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_pkg
// Shared Wishbone definitions: cycle-type (CTI) and burst-type (BTE) encodings
// and the state encoding used by the memory responder FSM.
// No ports; imported by the responder and its memory array.
// -----------------------------------------------------------------------------
package wishbone_pkg;

  // Cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Burst type extension
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } respStateT;

endpackage

// File: rtl/wishbone_mem_array.sv
// -----------------------------------------------------------------------------
// wishbone_mem_array
// Synchronous single-port RAM, 2^ADDR_WIDTH words of 32 bits, with four
// byte-write enables and a registered read port. No reset: contents and the
// read register power up undefined and survive reset of the surrounding logic.
//
// Ports:
//   clk       in   clock
//   en        in   access enable (read and/or write this edge)
//   we        in   1 = write the lanes selected by be
//   be        in   4  byte-lane enables, bit i -> bits [8i+7:8i]
//   addr      in   ADDR_WIDTH word address
//   wdata     in   32 write data
//   rdata     out  32 word read on the last enabled edge (value before write)
// -----------------------------------------------------------------------------
module wishbone_mem_array
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // Byte-lane write and read-first registered read of the addressed word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int lane = 0; lane < 4; lane++) begin
          if (be[lane]) begin
            mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
          end
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wishbone_mem_responder.sv
// -----------------------------------------------------------------------------
// wishbone_mem_responder
// Wishbone classic responder backed by a byte-writable word memory with a
// programmable number of wait states. Out-of-range addresses end with ERR.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   wb_ADR       in   30 word address
//   wb_DAT_MOSI  in   32 write data
//   wb_SEL       in   4  byte-lane enables
//   wb_CYC       in   bus cycle active
//   wb_STB       in   strobe (qualified by wb_CYC)
//   wb_WE        in   1 = write, 0 = read
//   wb_CTI       in   3  cycle type (ignored, all accesses classic)
//   wb_BTE       in   2  burst type (ignored)
//   wb_DAT_MISO  out  32 read data while wb_ACK, else 0
//   wb_ACK       out  normal termination
//   wb_ERR       out  error termination
// -----------------------------------------------------------------------------
module wishbone_mem_responder
  import wishbone_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] wb_ADR,
  input  logic [31:0] wb_DAT_MOSI,
  input  logic [3:0]  wb_SEL,
  input  logic        wb_CYC,
  input  logic        wb_STB,
  input  logic        wb_WE,
  input  logic [2:0]  wb_CTI,
  input  logic [1:0]  wb_BTE,
  output logic [31:0] wb_DAT_MISO,
  output logic        wb_ACK,
  output logic        wb_ERR
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  respStateT             stateQ;
  respStateT             stateD;
  logic [3:0]            cntQ;
  logic [ADDR_WIDTH-1:0] adrQ;
  logic [31:0]           datQ;
  logic [3:0]            selQ;
  logic                  weQ;
  logic                  inRangeQ;

  logic                  reqValid;
  logic                  reqInRange;
  logic                  memEn;
  logic                  memWe;
  logic [3:0]            memBe;
  logic [ADDR_WIDTH-1:0] memAdr;
  logic [31:0]           memWdata;
  logic [31:0]           memRdata;
  logic                  unusedBusInputs;

  // Every access is treated as classic, so cycle/burst type carry no meaning
  assign unusedBusInputs = ^{wb_CTI, wb_BTE};

  assign reqValid   = wb_CYC & wb_STB;
  assign reqInRange = ((wb_ADR >> ADDR_WIDTH) == 30'd0);

  // Next-state decode and memory commit on RESP entry
  always_comb begin
    stateD   = stateQ;
    memEn    = 1'b0;
    memWe    = 1'b0;
    memAdr   = adrQ;
    memWdata = datQ;
    memBe    = selQ;
    case (stateQ)
      IDLE: begin
        if (reqValid) begin
          if (WAIT_CYCLES > 0) begin
            stateD = WAIT;
          end else begin
            // Zero wait states: commit straight from the bus on acceptance,
            // because the capture registers only load on this same edge.
            stateD   = RESP;
            memEn    = reqInRange;
            memWe    = wb_WE;
            memAdr   = wb_ADR[ADDR_WIDTH-1:0];
            memWdata = wb_DAT_MOSI;
            memBe    = wb_SEL;
          end
        end else begin
          stateD = IDLE;
        end
      end
      WAIT: begin
        if (!wb_CYC) begin
          stateD = IDLE;
        end else if (cntQ == 4'd1) begin
          stateD = RESP;
          memEn  = inRangeQ;
          memWe  = weQ;
        end else begin
          stateD = WAIT;
        end
      end
      RESP: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // FSM state, wait counter and request capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= IDLE;
      cntQ     <= 4'd0;
      adrQ     <= '0;
      datQ     <= 32'd0;
      selQ     <= 4'd0;
      weQ      <= 1'b0;
      inRangeQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if ((stateQ == IDLE) && reqValid) begin
        cntQ     <= WAIT_LOAD;
        adrQ     <= wb_ADR[ADDR_WIDTH-1:0];
        datQ     <= wb_DAT_MOSI;
        selQ     <= wb_SEL;
        weQ      <= wb_WE;
        inRangeQ <= reqInRange;
      end else if ((stateQ == WAIT) && (cntQ != 4'd0)) begin
        cntQ <= cntQ - 4'd1;
      end else begin
        cntQ <= cntQ;
      end
    end
  end

  // Reset overrides any commit scheduled for this edge, discarding the write
  wishbone_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uMem (
    .clk  (clk),
    .en   (memEn & ~reset),
    .we   (memWe),
    .be   (memBe),
    .addr (memAdr),
    .wdata(memWdata),
    .rdata(memRdata)
  );

  // Outputs are FSM/RAM register state, gated only by CYC
  assign wb_ACK      = (stateQ == RESP) & inRangeQ & wb_CYC;
  assign wb_ERR      = (stateQ == RESP) & ~inRangeQ & wb_CYC;
  assign wb_DAT_MISO = wb_ACK ? memRdata : 32'd0;

endmodule

// File: tb/tb_wishbone_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_wishbone_mem_responder
// Four responder instances with WAIT_CYCLES = 0..3 (instance index equals its
// wait count) share address/data/select/write-enable; each has its own CYC/STB.
// -----------------------------------------------------------------------------
module tb_wishbone_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] adr;
  logic [31:0] mosi;
  logic [3:0]  sel;
  logic        we;
  logic [3:0]  cyc;
  logic [3:0]  stb;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [31:0] miso [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          inst;
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        expErr;
    logic [31:0] expData;
    logic        chk;
  } vecT;

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic        chk;
    int          lat;
  } expT;

  expT sbq[$];
  vecT vecs[16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gInst
    wishbone_mem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_CYCLES(g)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .wb_ADR     (adr),
      .wb_DAT_MOSI(mosi),
      .wb_SEL     (sel),
      .wb_CYC     (cyc[g]),
      .wb_STB     (stb[g]),
      .wb_WE      (we),
      .wb_CTI     (3'b000),
      .wb_BTE     (2'b00),
      .wb_DAT_MISO(miso[g]),
      .wb_ACK     (ack[g]),
      .wb_ERR     (err[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One classic transfer on instance i; expectation goes through the scoreboard
  task automatic xfer(input int i, input logic w, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic expErr, input logic [31:0] expData,
                      input logic chk);
    expT e;
    expT got;
    int  lat;
    logic seen;
    @(negedge clk);
    adr = a; mosi = d; sel = s; we = w;
    cyc[i] = 1'b1; stb[i] = 1'b1;
    e.err = expErr; e.data = expData; e.chk = chk; e.lat = 1 + i;
    sbq.push_back(e);
    @(posedge clk);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack[i] || err[i]) seen = 1'b1;
    end
    stb[i] = 1'b0;
    got = sbq.pop_front();
    check("resp_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(lat), 32'(got.lat));
      check("ack", 32'(ack[i]), 32'(!got.err));
      check("err", 32'(err[i]), 32'(got.err));
      if (got.err) check("err_data_zero", miso[i], 32'd0);
      else if (got.chk) check("rdata", miso[i], got.data);
    end
    @(negedge clk);
    check("single_cycle", 32'({ack[i], err[i]}), 32'd0);
    cyc[i] = 1'b0;
  endtask

  initial begin
    expT got;
    int  nAck;
    int  nErr;
    int  lastT;
    logic anyResp;
    logic [31:0] b2bData [4];

    reset = 1'b1;
    adr = 30'd0; mosi = 32'd0; sel = 4'd0; we = 1'b0;
    cyc = 4'd0; stb = 4'd0;

    vecs[0]  = '{2, 1'b1, 30'd5,    32'hDEADBEEF, 4'b1111, 1'b0, 32'd0,         1'b0};
    vecs[1]  = '{2, 1'b0, 30'd5,    32'd0,        4'b1111, 1'b0, 32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1, 1'b1, 30'd3,    32'h11223344, 4'b1111, 1'b0, 32'd0,         1'b0};
    vecs[3]  = '{1, 1'b1, 30'd3,    32'hAABBCCDD, 4'b0101, 1'b0, 32'd0,         1'b0};
    vecs[4]  = '{1, 1'b0, 30'd3,    32'd0,        4'b1111, 1'b0, 32'h11BB33DD, 1'b1};
    vecs[5]  = '{1, 1'b1, 30'd3,    32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0,         1'b0};
    vecs[6]  = '{1, 1'b0, 30'd3,    32'd0,        4'b1111, 1'b0, 32'h11BB33DD, 1'b1};
    vecs[7]  = '{1, 1'b1, 30'd0,    32'h0BADF00D, 4'b1111, 1'b0, 32'd0,         1'b0};
    vecs[8]  = '{1, 1'b1, 30'd1024, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'd0,         1'b0};
    vecs[9]  = '{1, 1'b0, 30'd1024, 32'd0,        4'b1111, 1'b1, 32'd0,         1'b0};
    vecs[10] = '{1, 1'b0, 30'd0,    32'd0,        4'b1111, 1'b0, 32'h0BADF00D, 1'b1};
    vecs[11] = '{0, 1'b1, 30'd10,   32'hA0A0A0A0, 4'b1111, 1'b0, 32'd0,         1'b0};
    vecs[12] = '{0, 1'b1, 30'd11,   32'hB1B1B1B1, 4'b1111, 1'b0, 32'd0,         1'b0};
    vecs[13] = '{0, 1'b1, 30'd12,   32'hC2C2C2C2, 4'b1111, 1'b0, 32'd0,         1'b0};
    vecs[14] = '{0, 1'b1, 30'd13,   32'hD3D3D3D3, 4'b1111, 1'b0, 32'd0,         1'b0};
    vecs[15] = '{0, 1'b0, 30'h3FFFFFFF, 32'd0,    4'b1111, 1'b1, 32'd0,         1'b0};

    b2bData[0] = 32'hA0A0A0A0; b2bData[1] = 32'hB1B1B1B1;
    b2bData[2] = 32'hC2C2C2C2; b2bData[3] = 32'hD3D3D3D3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state: outputs low even with CYC asserted
    cyc = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("reset_ack", 32'(ack[i]), 32'd0);
      check("reset_err", 32'(err[i]), 32'd0);
      check("reset_dat", miso[i], 32'd0);
    end
    cyc = 4'b0000;

    // Table-driven transfers
    for (int v = 0; v < 16; v++) begin
      xfer(vecs[v].inst, vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel,
           vecs[v].expErr, vecs[v].expData, vecs[v].chk);
    end

    // Abort: WAIT_CYCLES=3, CYC dropped one cycle after acceptance
    xfer(3, 1'b1, 30'd7, 32'h12345678, 4'b1111, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    adr = 30'd7; mosi = 32'hCAFEF00D; sel = 4'b1111; we = 1'b1;
    cyc[3] = 1'b1; stb[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc[3] = 1'b0; stb[3] = 1'b0;
    anyResp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      anyResp = anyResp | ack[3] | err[3];
    end
    check("abort_no_resp", 32'(anyResp), 32'd0);
    xfer(3, 1'b0, 30'd7, 32'd0, 4'b1111, 1'b0, 32'h12345678, 1'b1);

    // Back-to-back reads with CYC/STB held, WAIT_CYCLES=0
    nAck = 0; nErr = 0; lastT = -1;
    @(negedge clk);
    adr = 30'd10; we = 1'b0; sel = 4'b1111;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    got.err = 1'b0; got.data = b2bData[0]; got.chk = 1'b1; got.lat = 1;
    sbq.push_back(got);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (err[0]) nErr++;
      if (ack[0]) begin
        nAck++;
        if (sbq.size() > 0) begin
          got = sbq.pop_front();
          check("b2b_rdata", miso[0], got.data);
        end else begin
          check("b2b_extra_ack", 32'(nAck), 32'd4);
        end
        if (lastT >= 0) check("b2b_spacing", 32'(t - lastT), 32'd2);
        lastT = t;
        if (nAck < 4) begin
          adr = 30'd10 + 30'(nAck);
          got.err = 1'b0; got.data = b2bData[nAck]; got.chk = 1'b1; got.lat = 1;
          sbq.push_back(got);
        end else begin
          stb[0] = 1'b0;
        end
      end
    end
    cyc[0] = 1'b0;
    check("b2b_ack_count", 32'(nAck), 32'd4);
    check("b2b_no_err", 32'(nErr), 32'd0);
    check("b2b_queue_empty", 32'(sbq.size()), 32'd0);

    // Reset in the WAIT cycle of a pending write, WAIT_CYCLES=1
    xfer(1, 1'b1, 30'd20, 32'h55AA55AA, 4'b1111, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    adr = 30'd20; mosi = 32'hFFFF0000; sel = 4'b1111; we = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    stb[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_during_ack", 32'(ack[1]), 32'd0);
      check("rst_during_err", 32'(err[1]), 32'd0);
      check("rst_during_dat", miso[1], 32'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_after_ack", 32'(ack[1]), 32'd0);
      check("rst_after_err", 32'(err[1]), 32'd0);
      check("rst_after_dat", miso[1], 32'd0);
    end
    cyc[1] = 1'b0;
    xfer(1, 1'b0, 30'd20, 32'd0, 4'b1111, 1'b0, 32'h55AA55AA, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
